// File: rtl/scoreboard_register_file.sv
// Register file with per-register busy scoreboard; RAW/WAW hazards gate issue.
// Latency: reads are combinational, write-back and reservations take effect at the next clock edge.
// Backpressure: issue_ready drops while a source or the destination is reserved; write-back is never stalled.
//
// Ports:
//   clock, reset_n                      clock and asynchronous active-low reset
//   rs1_addr/rs2_addr -> rs*_data/busy  combinational read ports with busy status
//   issue_valid/issue_rd/issue_uses_rd  issue request; issue_ready is the hazard-free grant
//   wb_valid/wb_addr/wb_data            write-back; clears the busy bit of wb_addr
//   busy_count                          registered number of busy registers
//   wb_err                              sticky: write-back hit a register that was not busy
// Optional feature: define WRITE_BYPASS_EN to forward write-back data and
// release busy status in the write-back cycle itself.
module scoreboard_register_file #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            issue_uses_rd,
    output logic            issue_ready,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [AW:0]     busy_count,
    output logic            wb_err
);

`ifdef WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [AW:0]      r_busy_count;
    logic             r_wb_err;

    logic [NREGS-1:0] w_wb_hit;     // one-hot write-back target, hardwired zero excluded
    logic [NREGS-1:0] w_set;        // one-hot reservation on fire
    logic [NREGS-1:0] w_busy_eff;
    logic [NREGS-1:0] w_busy_nxt;
    logic [AW:0]      w_cnt_nxt;
    logic             w_fire;
    logic             w_wb_err_evt;
    logic             w_rs1_zero;
    logic             w_rs2_zero;

    always_comb begin
        w_wb_hit = '0;
        w_set    = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_wb_hit[i] = wb_valid && (wb_addr == AW'(i)) && !(ZERO_EN && (i == 0));
            w_set[i]    = w_fire && issue_uses_rd && (issue_rd == AW'(i))
                          && !(ZERO_EN && (i == 0));
        end
    end

    // With bypass, a register being written back this cycle already counts as free.
    assign w_busy_eff = BYPASS ? (r_busy & ~w_wb_hit) : r_busy;

    assign w_rs1_zero = ZERO_EN && (rs1_addr == '0);
    assign w_rs2_zero = ZERO_EN && (rs2_addr == '0);

    always_comb begin
        rs1_data = r_regs[rs1_addr];
        rs2_data = r_regs[rs2_addr];
        if (BYPASS && w_wb_hit[rs1_addr]) rs1_data = wb_data;
        if (BYPASS && w_wb_hit[rs2_addr]) rs2_data = wb_data;
        if (w_rs1_zero) rs1_data = '0;
        if (w_rs2_zero) rs2_data = '0;
    end

    assign rs1_busy    = w_busy_eff[rs1_addr];
    assign rs2_busy    = w_busy_eff[rs2_addr];
    assign issue_ready = ~rs1_busy & ~rs2_busy & ~(issue_uses_rd & w_busy_eff[issue_rd]);
    assign w_fire      = issue_valid & issue_ready;

    // Reservation is applied after the release so a same-cycle reserve wins.
    assign w_busy_nxt   = (r_busy & ~w_wb_hit) | w_set;
    assign w_wb_err_evt = |(w_wb_hit & ~r_busy);

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_busy_nxt[i]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_busy       <= '0;
            r_busy_count <= '0;
            r_wb_err     <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_busy       <= w_busy_nxt;
            r_busy_count <= w_cnt_nxt;
            if (w_wb_err_evt) r_wb_err <= 1'b1;
            for (int i = 0; i < NREGS; i++) begin
                if (w_wb_hit[i]) r_regs[i] <= wb_data;
            end
        end
    end

    assign busy_count = r_busy_count;
    assign wb_err     = r_wb_err;

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Self-checking bench for scoreboard_register_file (default parameters).
// A behavioural model is compared against the DUT on every falling clock edge,
// and directed steps pin hand-computed values.
module tb_scoreboard_register_file;

`ifdef WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0;
    logic [31:0] rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_uses_rd = 1'b0;
    logic        issue_ready;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [5:0]  busy_count;
    logic        wb_err;

    int total = 0;
    int bad   = 0;

    scoreboard_register_file dut (
        .clock(clock), .reset_n(reset_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_uses_rd(issue_uses_rd), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy_count(busy_count), .wb_err(wb_err)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    bit [31:0] m_regs [32];
    bit        m_busy [32];
    bit        m_err;
    int        m_cnt;
    bit        m_fire;

    function automatic bit m_beff(input int a);
        if (BYP && wb_valid && int'(wb_addr) == a && a != 0) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic bit [31:0] m_data(input int a);
        if (a == 0) return 32'h0;
        if (BYP && wb_valid && int'(wb_addr) == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic bit m_ready();
        return !m_beff(int'(rs1_addr)) && !m_beff(int'(rs2_addr))
               && !(issue_uses_rd && m_beff(int'(issue_rd)));
    endfunction

    always @(negedge reset_n) begin
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_err = 1'b0;
        m_cnt = 0;
    end

    always @(posedge clock) begin
        if (reset_n) begin
            m_fire = issue_valid && m_ready();
            if (wb_valid && wb_addr != 0) begin
                if (!m_busy[wb_addr]) m_err = 1'b1;
                m_busy[wb_addr] = 1'b0;
                m_regs[wb_addr] = wb_data;
            end
            if (m_fire && issue_uses_rd && issue_rd != 0) m_busy[issue_rd] = 1'b1;
            m_cnt = 0;
            for (int i = 0; i < 32; i++) m_cnt += int'(m_busy[i]);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("cmp_rs1_data", 64'(rs1_data), 64'(m_data(int'(rs1_addr))));
        chk("cmp_rs2_data", 64'(rs2_data), 64'(m_data(int'(rs2_addr))));
        chk("cmp_rs1_busy", 64'(rs1_busy), 64'(m_beff(int'(rs1_addr))));
        chk("cmp_rs2_busy", 64'(rs2_busy), 64'(m_beff(int'(rs2_addr))));
        chk("cmp_ready",    64'(issue_ready), 64'(m_ready()));
        chk("cmp_count",    64'(busy_count), 64'(m_cnt));
        chk("cmp_wb_err",   64'(wb_err), 64'(m_err));
    end

    // ---------------- directed stimulus ----------------
    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic drv(input int r1, input int r2, input bit iv, input int ird, input bit iu,
                       input bit wv, input int wa, input logic [31:0] wd);
        rs1_addr      = 5'(r1);
        rs2_addr      = 5'(r2);
        issue_valid   = iv;
        issue_rd      = 5'(ird);
        issue_uses_rd = iu;
        wb_valid      = wv;
        wb_addr       = 5'(wa);
        wb_data       = wd;
    endtask

    initial begin
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step;
        reset_n = 1'b1;

        // Reset state: every register reads zero.
        for (int i = 0; i < 32; i++) begin
            drv(i, 31 - i, 0, 0, 0, 0, 0, 0);
            #1;
            if (i % 8 == 3) begin
                chk("rst_rs1_data", 64'(rs1_data), 64'h0);
                chk("rst_rs2_data", 64'(rs2_data), 64'h0);
                chk("rst_ready", 64'(issue_ready), 64'h1);
            end
            step;
        end
        chk("rst_count", 64'(busy_count), 64'h0);
        chk("rst_wb_err", 64'(wb_err), 64'h0);

        // RAW hazard on register 5.
        drv(0, 0, 1, 5, 1, 0, 0, 0);
        #1 chk("issue5_ready", 64'(issue_ready), 64'h1);
        step;
        drv(5, 0, 1, 6, 1, 0, 0, 0);
        #1;
        chk("raw5_ready", 64'(issue_ready), 64'h0);
        chk("raw5_busy", 64'(rs1_busy), 64'h1);
        chk("raw5_count", 64'(busy_count), 64'h1);
        step;
        drv(5, 0, 1, 6, 1, 1, 5, 32'hDEADBEEF);
        #1;
        if (BYP) begin
            chk("wb5_ready_byp", 64'(issue_ready), 64'h1);
            chk("wb5_data_byp", 64'(rs1_data), 64'hDEADBEEF);
        end else begin
            chk("wb5_ready", 64'(issue_ready), 64'h0);
        end
        step;
        if (BYP) drv(5, 0, 0, 6, 0, 0, 0, 0);
        else     drv(5, 0, 1, 6, 1, 0, 0, 0);
        #1;
        chk("post5_ready", 64'(issue_ready), 64'h1);
        chk("post5_data", 64'(rs1_data), 64'hDEADBEEF);
        chk("post5_busy", 64'(rs1_busy), 64'h0);
        step;
        drv(6, 0, 0, 0, 0, 1, 6, 32'h66);
        step;
        drv(6, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("clr6_count", 64'(busy_count), 64'h0);
        chk("clr6_wb_err", 64'(wb_err), 64'h0);
        chk("clr6_data", 64'(rs1_data), 64'h66);

        // Hardwired zero register.
        drv(0, 0, 1, 0, 1, 1, 0, 32'h1234);
        #1 chk("zero_ready", 64'(issue_ready), 64'h1);
        step;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("zero_count", 64'(busy_count), 64'h0);
        chk("zero_data", 64'(rs1_data), 64'h0);
        chk("zero_wb_err", 64'(wb_err), 64'h0);

        // Issue to 7 and write-back to 7 in the same cycle while 7 is busy.
        drv(0, 0, 1, 7, 1, 0, 0, 0);
        step;
        drv(7, 0, 1, 7, 1, 1, 7, 32'hA5);
        #1 chk("same7_ready", 64'(issue_ready), 64'(BYP));
        step;
        drv(7, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("same7_data", 64'(rs1_data), 64'hA5);
        chk("same7_count", 64'(busy_count), BYP ? 64'h1 : 64'h0);
        chk("same7_busy", 64'(rs1_busy), 64'(BYP));
        chk("same7_wb_err", 64'(wb_err), 64'h0);
        if (BYP) begin
            drv(7, 0, 0, 0, 0, 1, 7, 32'hA5);
            step;
            drv(0, 0, 0, 0, 0, 0, 0, 0);
        end

        // Write-back to a register that is not busy.
        drv(9, 0, 0, 0, 0, 1, 9, 32'h1);
        #1 chk("err9_before", 64'(wb_err), 64'h0);
        step;
        drv(9, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("err9_set", 64'(wb_err), 64'h1);
        chk("err9_data", 64'(rs1_data), 64'h1);
        step;
        chk("err9_sticky", 64'(wb_err), 64'h1);

        // Reserve wins over same-cycle write-back on a free register.
        drv(8, 0, 1, 8, 1, 1, 8, 32'h88);
        #1 chk("rw8_ready", 64'(issue_ready), 64'h1);
        step;
        drv(8, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rw8_count", 64'(busy_count), 64'h1);
        chk("rw8_busy", 64'(rs1_busy), 64'h1);
        chk("rw8_data", 64'(rs1_data), 64'h88);
        drv(0, 0, 0, 0, 0, 1, 8, 32'h89);
        step;
        drv(0, 0, 0, 0, 0, 0, 0, 0);

        // Reserve 1..31, then reset mid-cycle.
        for (int i = 1; i < 32; i++) begin
            drv(0, 0, 1, i, 1, 0, 0, 0);
            step;
        end
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("full_count", 64'(busy_count), 64'd31);
        chk("full_ready", 64'(issue_ready), 64'h0);
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_count", 64'(busy_count), 64'h0);
        chk("arst_ready", 64'(issue_ready), 64'h1);
        chk("arst_busy", 64'(rs1_busy), 64'h0);
        chk("arst_wb_err", 64'(wb_err), 64'h0);
        step;
        step;
        reset_n = 1'b1;
        step;
        step;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
